// File: rtl/burst_mac_pkg.sv
// Shared definitions for the burst multiply-accumulate stage: FSM encoding,
// data/weight widths and the per-beat product helper.
package burst_mac_pkg;

    localparam int DATA_W      = 8;
    localparam int WGT_W       = 8;
    localparam int WPTR_W      = 3;
    localparam int WBANK_DEPTH = 8;
    localparam int PROD_W      = 17;

    // Encoding is shared with the buffer stage, hence the 8-bit width.
    typedef enum logic [7:0] {
        ST_IDLE = 8'd0,
        ST_ACC  = 8'd1,
        ST_OUT  = 8'd2
    } state_e;

    // Unsigned pixel times signed weight; the exact result always fits 17 signed bits.
    function automatic logic signed [PROD_W-1:0] beat_product(
        input logic [DATA_W-1:0] pix,
        input logic [WGT_W-1:0]  wgt
    );
        logic signed [PROD_W-1:0] pix_ext;
        logic signed [PROD_W-1:0] wgt_ext;
        pix_ext      = PROD_W'($signed({1'b0, pix}));
        wgt_ext      = PROD_W'($signed(wgt));
        beat_product = pix_ext * wgt_ext;
    endfunction

endpackage

// File: rtl/burst_mac_wbank.sv
// Eight-entry weight register file with an auto-incrementing write pointer
// and a combinational read port indexed by the current beat.
module burst_mac_wbank
    import burst_mac_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [WGT_W-1:0]  wr_data,
    input  logic [WPTR_W-1:0] rd_idx,
    output logic [WGT_W-1:0]  rd_data
);

    logic [WGT_W-1:0]  wgt_r [WBANK_DEPTH];
    logic [WPTR_W-1:0] wptr_r;

    // Weight storage and write pointer; the pointer wraps naturally at 8 entries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < WBANK_DEPTH; i++) begin
                wgt_r[i] <= '0;
            end
            wptr_r <= '0;
        end else if (wr_en) begin
            wgt_r[wptr_r] <= wr_data;
            wptr_r        <= wptr_r + 3'd1;
        end
    end

    assign rd_data = wgt_r[rd_idx];

endmodule

// File: rtl/burst_mac.sv
// Burst dot-product engine: accumulates BURST_LEN pixel*weight beats, then
// presents a full-precision and an 8-bit quantised result for one cycle.
module burst_mac
    import burst_mac_pkg::*;
#(
    parameter int BURST_LEN = 8,
    parameter int ACC_W     = 20,
    parameter int Q_SHIFT   = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_en,
    input  logic [DATA_W-1:0]       in_data,
    input  logic                    w_load,
    input  logic [WGT_W-1:0]        w_data,
    input  logic                    relu_en,
    output logic signed [ACC_W-1:0] res_data,
    output logic [DATA_W-1:0]       q_data,
    output logic                    res_valid,
    output logic                    busy,
    output logic                    drop_err
);

    localparam int                      CNT_W     = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [CNT_W-1:0]        LAST_BEAT = CNT_W'(BURST_LEN - 1);
    localparam logic signed [ACC_W-1:0] Q_MAX     = ACC_W'(8'd255);

    state_e                   state_r;
    state_e                   next_state_s;
    logic [CNT_W-1:0]         beat_cnt_r;
    logic signed [ACC_W-1:0]  acc_r;
    logic signed [ACC_W-1:0]  res_data_r;
    logic [DATA_W-1:0]        q_data_r;
    logic                     res_valid_r;
    logic                     busy_r;
    logic                     drop_err_r;

    logic                     accept_s;
    logic                     last_s;
    logic                     wr_en_s;
    logic                     drop_s;
    logic [WGT_W-1:0]         wgt_s;
    logic [WPTR_W-1:0]        rd_idx_s;
    logic signed [PROD_W-1:0] prod_s;
    logic signed [ACC_W-1:0]  acc_next_s;

    // Negative results always land on zero, so relu only matters for readability.
    function automatic logic [DATA_W-1:0] quantise(
        input logic signed [ACC_W-1:0] val,
        input logic                    relu
    );
        logic signed [ACC_W-1:0] sh;
        sh = val >>> Q_SHIFT;
        if (relu && val[ACC_W-1]) begin
            quantise = '0;
        end else if (sh[ACC_W-1]) begin
            quantise = '0;
        end else if (sh > Q_MAX) begin
            quantise = 8'd255;
        end else begin
            quantise = sh[DATA_W-1:0];
        end
    endfunction

    burst_mac_wbank u_wbank (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en_s),
        .wr_data (w_data),
        .rd_idx  (rd_idx_s),
        .rd_data (wgt_s)
    );

    // Beat acceptance, weight-write qualification and the next accumulator value.
    always_comb begin
        accept_s   = in_en && ((state_r == ST_IDLE) || (state_r == ST_ACC));
        last_s     = accept_s && (beat_cnt_r == LAST_BEAT);
        wr_en_s    = w_load && (state_r == ST_IDLE) && !in_en;
        drop_s     = (in_en && (state_r == ST_OUT)) || (w_load && !wr_en_s);
        rd_idx_s   = WPTR_W'(beat_cnt_r);
        prod_s     = beat_product(in_data, wgt_s);
        acc_next_s = acc_r + ACC_W'(prod_s);
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    next_state_s = last_s ? ST_OUT : ST_ACC;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_ACC: begin
                if (last_s) begin
                    next_state_s = ST_OUT;
                end else begin
                    next_state_s = ST_ACC;
                end
            end
            ST_OUT:  next_state_s = ST_IDLE;
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Accumulator, beat counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r       <= '0;
            beat_cnt_r  <= '0;
            res_data_r  <= '0;
            q_data_r    <= '0;
            res_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            drop_err_r  <= 1'b0;
        end else begin
            if (accept_s && !last_s) begin
                acc_r      <= acc_next_s;
                beat_cnt_r <= beat_cnt_r + CNT_W'(1);
            end else if (last_s || (state_r != ST_ACC)) begin
                // Cleared ahead of the return to IDLE; ACC gaps fall through and hold.
                acc_r      <= '0;
                beat_cnt_r <= '0;
            end
            if (last_s) begin
                res_data_r <= acc_next_s;
                q_data_r   <= quantise(acc_next_s, relu_en);
            end
            res_valid_r <= last_s;
            busy_r      <= (next_state_s != ST_IDLE);
            drop_err_r  <= drop_s;
        end
    end

    assign res_data  = res_data_r;
    assign q_data    = q_data_r;
    assign res_valid = res_valid_r;
    assign busy      = busy_r;
    assign drop_err  = drop_err_r;

endmodule

// File: tb/tb_burst_mac.sv
// Randomised self-checking bench for burst_mac against an arithmetic model of
// weight loading, burst dot products and quantisation.
module tb_burst_mac;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_en;
    logic [7:0]        in_data;
    logic              w_load;
    logic [7:0]        w_data;
    logic              relu_en;
    logic signed [19:0] res_data;
    logic [7:0]        q_data;
    logic              res_valid;
    logic              busy;
    logic              drop_err;

    int total = 0;
    int bad   = 0;
    int mw[8];
    int mptr;
    int bd[8];

    always #5 clk = ~clk;

    burst_mac #(.BURST_LEN(8), .ACC_W(20), .Q_SHIFT(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_en     (in_en),
        .in_data   (in_data),
        .w_load    (w_load),
        .w_data    (w_data),
        .relu_en   (relu_en),
        .res_data  (res_data),
        .q_data    (q_data),
        .res_valid (res_valid),
        .busy      (busy),
        .drop_err  (drop_err)
    );

    task automatic check_val(input string tag, input longint got, input longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int sbyte(input int v);
        return (v > 127) ? v - 256 : v;
    endfunction

    // Dot product of the current burst with the model weights, wrapped to 20 signed bits.
    function automatic int exp_res();
        int sum = 0;
        for (int k = 0; k < 8; k++) sum += bd[k] * sbyte(mw[k]);
        sum = sum & 32'h000F_FFFF;
        if (sum >= 32'sd524288) sum -= 32'sd1048576;
        return sum;
    endfunction

    function automatic int exp_q(input int r, input bit relu);
        int sh = r >>> 4;
        if (relu && r < 0) return 0;
        if (sh < 0) return 0;
        if (sh > 255) return 255;
        return sh;
    endfunction

    task automatic load_w(input int v);
        w_load = 1'b1;
        w_data = 8'(v);
        in_en  = 1'b0;
        tick();
        w_load = 1'b0;
        check_val("wload_no_drop", drop_err, 0);
        mw[mptr] = v & 255;
        mptr     = (mptr + 1) % 8;
    endtask

    task automatic load_all(input int v);
        for (int i = 0; i < 8; i++) load_w(v);
    endtask

    // flags: bit0 w_load mid-burst, bit1 beat during OUT, bit2 w_load with beat 0.
    task automatic burst(input int gapmax, input bit relu, input int flags, input string tag);
        int r = exp_res();
        int q = exp_q(r, relu);
        for (int k = 0; k < 8; k++) begin
            int g = (k == 0) ? 0 : int'($urandom_range(gapmax, 0));
            if ((flags & 1) != 0 && k == 3) begin
                in_en  = 1'b0;
                w_load = 1'b1;
                w_data = 8'($urandom);
                tick();
                w_load = 1'b0;
                check_val({tag, "_drop_wload_acc"}, drop_err, 1);
                check_val({tag, "_busy_drop"}, busy, 1);
            end
            for (int gi = 0; gi < g; gi++) begin
                in_en = 1'b0;
                tick();
                check_val({tag, "_gap_busy"}, busy, 1);
            end
            in_en   = 1'b1;
            in_data = 8'(bd[k]);
            relu_en = (k == 7) ? relu : ~relu;
            if ((flags & 4) != 0 && k == 0) begin
                w_load = 1'b1;
                w_data = 8'($urandom);
            end
            tick();
            w_load = 1'b0;
            if ((flags & 4) != 0 && k == 0) check_val({tag, "_drop_wload_beat"}, drop_err, 1);
            if (k < 7) begin
                check_val({tag, "_early_valid"}, res_valid, 0);
                check_val({tag, "_busy_beat"}, busy, 1);
            end
        end
        check_val({tag, "_valid"}, res_valid, 1);
        check_val({tag, "_res"}, res_data, r);
        check_val({tag, "_q"}, q_data, q);
        check_val({tag, "_busy_out"}, busy, 1);
        in_en   = ((flags & 2) != 0);
        in_data = 8'($urandom);
        relu_en = 1'($urandom);
        tick();
        in_en = 1'b0;
        check_val({tag, "_drop_out"}, drop_err, ((flags & 2) != 0) ? 1 : 0);
        check_val({tag, "_valid_one"}, res_valid, 0);
        check_val({tag, "_idle"}, busy, 0);
        check_val({tag, "_res_hold"}, res_data, r);
        check_val({tag, "_q_hold"}, q_data, q);
    endtask

    task automatic check_zero(input string tag);
        check_val({tag, "_res"}, res_data, 0);
        check_val({tag, "_q"}, q_data, 0);
        check_val({tag, "_valid"}, res_valid, 0);
        check_val({tag, "_busy"}, busy, 0);
        check_val({tag, "_drop"}, drop_err, 0);
    endtask

    initial begin
        rst_n   = 1'b0;
        in_en   = 1'b0;
        in_data = 8'd0;
        w_load  = 1'b0;
        w_data  = 8'd0;
        relu_en = 1'b0;
        mptr    = 0;
        for (int i = 0; i < 8; i++) mw[i] = 0;
        #12;
        check_zero("reset");
        #10;
        rst_n = 1'b1;
        tick();

        load_all(1);
        for (int k = 0; k < 8; k++) bd[k] = k + 1;
        burst(0, 1'b0, 0, "ramp");

        load_all(8'hFF);
        for (int k = 0; k < 8; k++) bd[k] = 255;
        burst(0, 1'b1, 0, "neg_relu");
        burst(0, 1'b0, 0, "neg_sat");

        load_all(127);
        burst(5, 1'b0, 0, "max_gaps");

        for (int k = 0; k < 8; k++) bd[k] = int'($urandom_range(255, 0));
        burst(2, 1'b0, 3, "drops");
        for (int k = 0; k < 8; k++) bd[k] = int'($urandom_range(255, 0));
        burst(1, 1'b1, 0, "after_drops");
        burst(0, 1'b0, 4, "drop_coinc");

        load_w(2);
        for (int i = 0; i < 7; i++) load_w(1);
        load_w(3);
        for (int k = 0; k < 8; k++) bd[k] = 1;
        burst(0, 1'b0, 0, "wrap");

        // Abort a burst after beat 4 with an asynchronous reset.
        for (int i = 0; i < 8; i++) load_w(int'($urandom_range(255, 0)));
        for (int k = 0; k < 4; k++) begin
            in_en   = 1'b1;
            in_data = 8'($urandom);
            tick();
        end
        rst_n = 1'b0;
        in_en = 1'b0;
        #1;
        check_zero("mid_reset");
        mptr = 0;
        for (int i = 0; i < 8; i++) mw[i] = 0;
        tick();
        #2;
        rst_n = 1'b1;
        tick();
        check_val("post_reset_valid", res_valid, 0);
        for (int i = 0; i < 8; i++) load_w(int'($urandom_range(255, 0)));
        for (int k = 0; k < 8; k++) bd[k] = int'($urandom_range(255, 0));
        burst(1, 1'b0, 0, "post_reset");

        for (int n = 0; n < 25; n++) begin
            int nl = int'($urandom_range(10, 0));
            for (int i = 0; i < nl; i++) load_w(int'($urandom_range(255, 0)));
            for (int k = 0; k < 8; k++) bd[k] = int'($urandom_range(255, 0));
            burst(int'($urandom_range(3, 0)), 1'($urandom), int'($urandom_range(7, 0)), "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/burst_mac.md
BURST_MAC -- requirements
Module: burst_mac

Interface
REQ-001 SHALL have parameter BURST_LEN, default 8: beats per burst.
REQ-002 SHALL have parameter ACC_W, default 20: signed accumulator width.
REQ-003 SHALL have parameter Q_SHIFT, default 4: right shift applied before 8-bit quantisation.
REQ-004 SHALL have port clk, input, 1: single clock, rising edge.
REQ-005 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port in_en, input, 1: upstream buffer read-out beat valid.
REQ-007 SHALL have port in_data, input, 8: unsigned pixel byte.
REQ-008 SHALL have port w_load, input, 1: weight write strobe.
REQ-009 SHALL have port w_data, input, 8: signed weight byte.
REQ-010 SHALL have port relu_en, input, 1: clamp negative results to zero on q_data.
REQ-011 SHALL have port res_data, output, ACC_W: signed full-precision dot product.
REQ-012 SHALL have port q_data, output, 8: quantised unsigned result.
REQ-013 SHALL have port res_valid, output, 1: one-cycle result strobe.
REQ-014 SHALL have port busy, output, 1: high in ACC and OUT states.
REQ-015 SHALL have port drop_err, output, 1: one-cycle pulse when a beat is discarded.

Function
REQ-016 SHALL implement FSM states IDLE, ACC, OUT.
REQ-017 IDLE with in_en=1 SHALL accept beat 0 and go to ACC, or go to OUT directly if BURST_LEN=1.
REQ-018 ACC SHALL accept every in_en=1 cycle as the next beat and SHALL hold state and accumulator on in_en=0 gaps of any length.
REQ-019 On acceptance of beat BURST_LEN-1, the FSM SHALL go to OUT.
REQ-020 OUT SHALL last exactly one cycle and then return to IDLE.
REQ-021 Beat k SHALL contribute zero-extended in_data times sign-extended weight[k], as a 17-bit signed product, sign-extended into the accumulator.
REQ-022 Accumulation SHALL wrap modulo 2^ACC_W with no saturation; ACC_W=20 is exact for 8 beats.
REQ-023 res_data SHALL be registered and SHALL update in the cycle after the last beat is accepted.
REQ-024 res_valid SHALL be high for exactly that cycle (the OUT state), giving one cycle of latency from the last beat.
REQ-025 res_data and q_data SHALL hold their values until the next result.
REQ-026 q_data SHALL be 0 if res_data<0 and relu_en=1; otherwise res_data arithmetic-shifted right by Q_SHIFT, saturated to 0..255 (negative values saturate to 0).
REQ-027 relu_en SHALL be sampled in the cycle the last beat is accepted.
REQ-028 The accumulator and beat counter SHALL clear on entry to IDLE.
REQ-029 in_en=1 during OUT SHALL be discarded and SHALL pulse drop_err in the same cycle, registered.
REQ-030 The weight bank SHALL hold 8 entries with a 3-bit write pointer.
REQ-031 A w_load=1 in IDLE with in_en=0 SHALL write w_data to weight[ptr] and then increment ptr, wrapping 7->0.
REQ-032 w_load in ACC or OUT, or coincident with in_en in IDLE, SHALL be ignored: no write, ptr unchanged, and drop_err pulsed.
REQ-033 busy SHALL equal (state != IDLE).

Reset
REQ-034 rst_n low SHALL asynchronously force state IDLE, accumulator 0, beat counter 0, and weight pointer 0.
REQ-035 rst_n low SHALL asynchronously force all weights 0, res_data 0, q_data 0, res_valid 0, drop_err 0, and busy 0.
REQ-036 Reset deasserted mid-burst SHALL leave the partial burst discarded, with no res_valid.

Structure
REQ-037 A shared package SHALL hold the FSM state encoding (IDLE=0, ACC=1, OUT=2, 8-bit as used by the buffer stage) and the 8-bit data/weight width constants.
REQ-038 The weight register file and its pointer SHALL be one sub-module, burst_mac_wbank, with write port and 3-bit read index.

Verification
REQ-039 Load weights 1,1,1,1,1,1,1,1 and then burst data 1..8 back-to-back -> res_data=36, q_data=2, res_valid exactly one cycle after beat 8.
REQ-040 Load weights all -1 (0xFF) and burst 255 x8 with relu_en=1 -> res_data=-2040, q_data=0; repeat with relu_en=0 -> q_data=0 (saturate).
REQ-041 Load weights 127 x8 and burst 255 x8 with random in_en gaps of 0-5 cycles -> res_data=259080, q_data=255, busy high throughout.
REQ-042 Send in_en during OUT and w_load during ACC -> both drop_err pulses, next burst result unaffected, weights unchanged.
REQ-043 Load 9 weights (values 2, then 1 x7, then 3) -> weight[0]=3 after wrap; burst 1 x8 -> res_data=10.
REQ-044 Assert rst_n low after beat 4 of a burst -> all outputs 0 immediately; a following full burst with reloaded weights produces the correct sum.
